// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control/status bundle for the multi-channel clock divider.
// master drives enable, divisor writes and align; slave returns clocks, ticks, pending.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DIV_W-1:0]  wr_div;
    logic              align;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (
        output en, wr_en, wr_ch, wr_div, align,
        input  clk_out, tick, pending
    );

    modport slave (
        input  en, wr_en, wr_ch, wr_div, align,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent 50%-duty programmable clock dividers.
// Each channel toggles clk_out every D cycles (D = half period) and pulses tick
// on the toggle. New divisors are staged in pend_div and swapped in only at a
// terminal edge, so a running output never sees a short or stretched half period.
// Optional macro SYNC_ALIGN_EN: align pulse restarts every channel in phase.

module clk_div_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             align,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pend_div;
    logic             halted;
    logic             term;

    assign halted = (active_div == '0);
    assign term   = !halted && (count == active_div - DIV_W'(1));

    // Count/toggle/apply; a write in the same cycle is captured last so it always
    // survives, even over an apply that would otherwise clear pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            active_div <= DIV_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (align) begin
                count   <= '0;
                clk_out <= 1'b0;
                if (pending) begin
                    active_div <= pend_div;
                    pending    <= 1'b0;
                end
            end else if (halted) begin
                // Idle low; a staged divisor restarts the channel from a clean phase.
                count   <= '0;
                clk_out <= 1'b0;
                if (en && pending) begin
                    active_div <= pend_div;
                    pending    <= 1'b0;
                end
            end else if (en) begin
                if (term) begin
                    count   <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                    if (pending) begin
                        active_div <= pend_div;
                        pending    <= 1'b0;
                    end
                end else begin
                    count <= count + DIV_W'(1);
                end
            end
            if (wr) begin
                pend_div <= wr_div;
                pending  <= 1'b1;
            end
        end
    end
endmodule

module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1250,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    clk_div_multi_if.slave bus
);
    logic [NUM_CH-1:0] clk_out_v;
    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] pending_v;
    logic              align_w;

`ifdef SYNC_ALIGN_EN
    assign align_w = bus.align;
`else
    logic unused_align;
    assign unused_align = bus.align;
    assign align_w      = 1'b0;
`endif

    // Out-of-range channel indices match no lane, so such writes fall away.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.en),
            .wr      (bus.wr_en && (bus.wr_ch == CH_W'(i))),
            .wr_div  (bus.wr_div),
            .align   (align_w),
            .clk_out (clk_out_v[i]),
            .tick    (tick_v[i]),
            .pending (pending_v[i])
        );
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;
    assign bus.pending = pending_v;
endmodule
